// File: rtl/imem_port_arbiter_pkg.sv
// rtl/imem_port_arbiter_pkg.sv - response-owner state encodings and address-fault helper
package imem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RESP_F = 2'd1,
        S_RESP_L = 2'd2
    } resp_state_t;

    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_L = 1'b1;

    // 33-bit sum so addresses near 2^32 cannot wrap back into the legal range
    function automatic logic addr_fault(input logic [31:0] adr, input logic [32:0] limit);
        return (adr[1:0] != 2'b00) || (({1'b0, adr} + 33'd3) >= limit);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch/load requester and memory read-port bundle
interface imem_port_arbiter_if;

    logic        i_f_req;
    logic [31:0] i_f_adr;
    logic        i_flush;
    logic        o_f_gnt;
    logic        o_f_valid;
    logic [31:0] o_f_rdata;
    logic        o_f_err;

    logic        i_l_req;
    logic [31:0] i_l_adr;
    logic        o_l_gnt;
    logic        o_l_valid;
    logic [31:0] o_l_rdata;
    logic        o_l_err;

    logic [31:0] o_mem_adr;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_f_req, i_f_adr, i_flush, i_l_req, i_l_adr, i_mem_rdata,
        output o_f_gnt, o_f_valid, o_f_rdata, o_f_err,
        output o_l_gnt, o_l_valid, o_l_rdata, o_l_err, o_mem_adr
    );

    modport master (
        output i_f_req, i_f_adr, i_flush, i_l_req, i_l_adr, i_mem_rdata,
        input  o_f_gnt, o_f_valid, o_f_rdata, o_f_err,
        input  o_l_gnt, o_l_valid, o_l_rdata, o_l_err, o_mem_adr
    );

endinterface

// File: rtl/imem_arb_starve_ctr.sv
// rtl/imem_arb_starve_ctr.sv - counts consecutive denied fetch cycles, flags when fetch must win
module imem_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_guard
);

    logic [3:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= 4'd0;
        end else if (i_clr) begin
            cnt <= 4'd0;
        end else if (i_inc && (cnt != 4'(STARVE_MAX))) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign o_guard = (cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/load arbiter for the imem read port; optional IMEM_ARB_STARVE_GUARD_EN
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 32'h0010_0000,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    imem_port_arbiter_if.slave bus
);

    logic        guard;
    logic        f_ok;
    logic        f_gnt;
    logic        l_gnt;
    logic        owner;
    logic        f_fault;
    logic        l_fault;
    logic        gnt_fault;
    logic [31:0] mem_adr;
    logic [31:0] last_adr;
    resp_state_t state;
    logic [31:0] rdata_q;
    logic        err_q;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    imem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (bus.i_f_req && !bus.i_flush && l_gnt),
        .i_clr   (f_gnt || !bus.i_f_req || bus.i_flush),
        .o_guard (guard)
    );
`else
    logic [3:0] starve_max_unused;
    assign starve_max_unused = 4'(STARVE_MAX);
    assign guard = 1'b0;
`endif

    always_comb begin
        f_ok      = bus.i_f_req && !bus.i_flush && !i_rst;
        l_gnt     = bus.i_l_req && !i_rst && !(f_ok && guard);
        f_gnt     = f_ok && (!bus.i_l_req || guard);
        owner     = l_gnt ? OWNER_L : OWNER_F;
        f_fault   = addr_fault(bus.i_f_adr, 33'(MEM_BYTES));
        l_fault   = addr_fault(bus.i_l_adr, 33'(MEM_BYTES));
        gnt_fault = (owner == OWNER_L) ? l_fault : f_fault;
        // With no grant the port keeps its previous address so the memory sees no spurious toggles
        if (i_rst)      mem_adr = 32'd0;
        else if (l_gnt) mem_adr = bus.i_l_adr;
        else if (f_gnt) mem_adr = bus.i_f_adr;
        else            mem_adr = last_adr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            last_adr <= 32'd0;
        end else begin
            last_adr <= mem_adr;
            if (l_gnt || f_gnt) begin
                state   <= (owner == OWNER_L) ? S_RESP_L : S_RESP_F;
                rdata_q <= gnt_fault ? 32'd0 : bus.i_mem_rdata;
                err_q   <= gnt_fault;
            end else begin
                state   <= S_IDLE;
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // A flush in the response cycle discards a pending fetch word; reset drops any response
    logic f_valid;
    logic l_valid;
    assign f_valid = (state == S_RESP_F) && !bus.i_flush && !i_rst;
    assign l_valid = (state == S_RESP_L) && !i_rst;

    assign bus.o_f_gnt   = f_gnt;
    assign bus.o_l_gnt   = l_gnt;
    assign bus.o_mem_adr = mem_adr;
    assign bus.o_f_valid = f_valid;
    assign bus.o_f_rdata = f_valid ? rdata_q : 32'd0;
    assign bus.o_f_err   = f_valid && err_q;
    assign bus.o_l_valid = l_valid;
    assign bus.o_l_rdata = l_valid ? rdata_q : 32'd0;
    assign bus.o_l_err   = l_valid && err_q;

endmodule
